spi_frame_link: RTL and testbench

- Parametrised successor to the current single-frame SPI controller.
- TX side: serialises one {message, header} frame per ready/valid handshake, with a programmable bit clock and a defined chip-select hold.
- RX side: synchronises external SPI wires, checks frame length and buffers whole frames in a RX_DEPTH-entry FIFO with drop/length-error reporting.
- Sits between the crypto/packet pipeline and the board-to-board SPI wires.

---
 rtl/spi_frame_link.sv | 189 ++++++++++++++++++
 tb/tb_spi_frame_link.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_link.sv
// SPI frame link: serialises one {message, header} frame per handshake on TX and
// receives, length-checks and buffers whole frames from an asynchronous peer on RX.
module spi_frame_link #(
   parameter int unsigned MESSAGE_SIZE = 512,
   parameter int unsigned HEADER_SIZE  = 32,
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned RX_DEPTH     = 2
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [MESSAGE_SIZE-1:0]         tx_message_in,
   input  logic [HEADER_SIZE-1:0]          tx_header_in,
   input  logic                            tx_valid_in,
   output logic                            tx_ready_out,
   output logic                            tx_data_out,
   output logic                            tx_clk_out,
   output logic                            tx_sel_out,
   input  logic                            rx_data_in,
   input  logic                            rx_clk_in,
   input  logic                            rx_sel_in,
   output logic [MESSAGE_SIZE-1:0]         rx_message_out,
   output logic [HEADER_SIZE-1:0]          rx_header_out,
   output logic                            rx_valid_out,
   input  logic                            rx_ready_in,
   output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count_out,
   output logic                            rx_drop_out,
   output logic                            rx_len_err_out
);

   localparam int unsigned W      = MESSAGE_SIZE + HEADER_SIZE;
   localparam int unsigned DivW   = $clog2(CLK_DIV);
   localparam int unsigned BitW   = $clog2(W);
   localparam int unsigned RxBitW = $clog2(W + 2);
   localparam int unsigned PtrW   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int unsigned CntW   = $clog2(RX_DEPTH + 1);

   localparam logic [DivW-1:0]   DivLast = DivW'(CLK_DIV - 1);
   localparam logic [RxBitW-1:0] RxLen   = RxBitW'(W);
   localparam logic [RxBitW-1:0] RxSat   = RxBitW'(W + 1);
   localparam logic [PtrW-1:0]   PtrLast = PtrW'(RX_DEPTH - 1);
   localparam logic [CntW-1:0]   CntFull = CntW'(RX_DEPTH);

   typedef enum logic [1:0] {StIdle, StShift, StHold} tx_state_e;

   tx_state_e        tx_state_q;
   logic [W-1:0]     tx_shift_q;
   logic [DivW-1:0]  tx_div_q;
   logic [BitW-1:0]  tx_bit_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tx_state_q   <= StIdle;
         tx_shift_q   <= '0;
         tx_div_q     <= '0;
         tx_bit_q     <= '0;
         tx_ready_out <= 1'b1;
         tx_sel_out   <= 1'b1;
         tx_clk_out   <= 1'b0;
         tx_data_out  <= 1'b0;
      end else begin
         unique case (tx_state_q)
            StIdle: begin
               if (tx_valid_in) begin
                  tx_shift_q   <= {tx_message_in, tx_header_in};
                  tx_data_out  <= tx_message_in[MESSAGE_SIZE-1];
                  tx_bit_q     <= BitW'(W - 1);
                  tx_div_q     <= '0;
                  tx_ready_out <= 1'b0;
                  tx_sel_out   <= 1'b0;
                  tx_clk_out   <= 1'b0;
                  tx_state_q   <= StShift;
               end
            end
            StShift: begin
               if (tx_div_q == DivLast) begin
                  tx_div_q <= '0;
                  if (!tx_clk_out) begin
                     tx_clk_out <= 1'b1;
                  end else begin
                     tx_clk_out <= 1'b0;
                     if (tx_bit_q == '0) begin
                        tx_state_q <= StHold;
                     end else begin
                        // Next bit is presented as the clock falls
                        tx_bit_q    <= tx_bit_q - BitW'(1);
                        tx_shift_q  <= {tx_shift_q[W-2:0], 1'b0};
                        tx_data_out <= tx_shift_q[W-2];
                     end
                  end
               end else begin
                  tx_div_q <= tx_div_q + DivW'(1);
               end
            end
            StHold: begin
               if (tx_div_q == DivLast) begin
                  tx_div_q     <= '0;
                  tx_sel_out   <= 1'b1;
                  tx_ready_out <= 1'b1;
                  tx_state_q   <= StIdle;
               end else begin
                  tx_div_q <= tx_div_q + DivW'(1);
               end
            end
            default: tx_state_q <= StIdle;
         endcase
      end
   end

   // [0],[1] form the synchroniser, [2] is edge-detect history
   logic [2:0] sel_sync_q;
   logic [2:0] clk_sync_q;
   logic [1:0] dat_sync_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sel_sync_q <= 3'b111;
         clk_sync_q <= 3'b000;
         dat_sync_q <= 2'b00;
      end else begin
         sel_sync_q <= {sel_sync_q[1:0], rx_sel_in};
         clk_sync_q <= {clk_sync_q[1:0], rx_clk_in};
         dat_sync_q <= {dat_sync_q[0], rx_data_in};
      end
   end

   logic sel_fall, sel_rise, clk_rise;
   assign sel_fall = sel_sync_q[2] & ~sel_sync_q[1];
   assign sel_rise = ~sel_sync_q[2] & sel_sync_q[1];
   assign clk_rise = ~clk_sync_q[2] & clk_sync_q[1];

   logic [W-1:0]      rx_shift_q;
   logic [RxBitW-1:0] rx_cnt_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rx_shift_q <= '0;
         rx_cnt_q   <= '0;
      end else if (sel_fall) begin
         rx_shift_q <= '0;
         rx_cnt_q   <= '0;
      end else if (clk_rise && !sel_sync_q[1]) begin
         rx_shift_q <= {rx_shift_q[W-2:0], dat_sync_q[1]};
         if (rx_cnt_q != RxSat) rx_cnt_q <= rx_cnt_q + RxBitW'(1);
      end
   end

   logic [W-1:0]    fifo_q [RX_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] rx_count_q;
   logic            frame_ok, len_bad, full, pop, push, drop;

   assign frame_ok = sel_rise && (rx_cnt_q == RxLen);
   assign len_bad  = sel_rise && (rx_cnt_q != RxLen) && (rx_cnt_q != '0);
   assign full     = (rx_count_q == CntFull);
   assign pop      = rx_valid_out && rx_ready_in;
   assign push     = frame_ok && (!full || pop);
   assign drop     = frame_ok && full && !pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < RX_DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         rx_count_q     <= '0;
         rx_drop_out    <= 1'b0;
         rx_len_err_out <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= rx_shift_q;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop) rx_count_q <= rx_count_q + CntW'(1);
         else if (pop && !push) rx_count_q <= rx_count_q - CntW'(1);
         rx_drop_out    <= drop;
         rx_len_err_out <= len_bad;
      end
   end

   assign rx_valid_out   = (rx_count_q != '0);
   assign rx_count_out   = rx_count_q;
   assign rx_message_out = fifo_q[rd_ptr_q][W-1:HEADER_SIZE];
   assign rx_header_out  = fifo_q[rd_ptr_q][HEADER_SIZE-1:0];

endmodule

// File: tb/tb_spi_frame_link.sv
// Bench for spi_frame_link: TX looped back to RX, frame-level reference model checked
// every cycle plus directed scenarios with hand-computed results.
module tb_spi_frame_link;

   localparam int M = 8;
   localparam int H = 8;
   localparam int C = 2;
   localparam int D = 2;
   localparam int W = M + H;
   localparam int TxBusy = 2 * W * C + C;

   logic         clk = 1'b0;
   logic         rst_in = 1'b0;
   logic [M-1:0] tx_msg;
   logic [H-1:0] tx_hdr;
   logic         tx_valid;
   logic         tx_ready, tx_data, tx_clk, tx_sel;
   logic         rx_data_w, rx_clk_w, rx_sel_w;
   logic [M-1:0] rx_msg;
   logic [H-1:0] rx_hdr;
   logic         rx_valid, rx_ready;
   logic [1:0]   rx_count;
   logic         rx_drop, rx_lerr;
   logic         manual, m_sel, m_clk, m_data;

   assign rx_data_w = manual ? m_data : tx_data;
   assign rx_clk_w  = manual ? m_clk  : tx_clk;
   assign rx_sel_w  = manual ? m_sel  : tx_sel;

   spi_frame_link #(
      .MESSAGE_SIZE(M), .HEADER_SIZE(H), .CLK_DIV(C), .RX_DEPTH(D)
   ) dut (
      .clk_in(clk), .rst_in(rst_in),
      .tx_message_in(tx_msg), .tx_header_in(tx_hdr), .tx_valid_in(tx_valid),
      .tx_ready_out(tx_ready), .tx_data_out(tx_data), .tx_clk_out(tx_clk),
      .tx_sel_out(tx_sel),
      .rx_data_in(rx_data_w), .rx_clk_in(rx_clk_w), .rx_sel_in(rx_sel_w),
      .rx_message_out(rx_msg), .rx_header_out(rx_hdr), .rx_valid_out(rx_valid),
      .rx_ready_in(rx_ready), .rx_count_out(rx_count), .rx_drop_out(rx_drop),
      .rx_len_err_out(rx_lerr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {logic sel; logic clk; logic dat;} wire_t;
   localparam wire_t WIdle = '{sel: 1'b1, clk: 1'b0, dat: 1'b0};

   int           cyc = 0;
   bit           active = 0;
   int           acc = 0;
   logic [W-1:0] tx_frame;
   wire_t        hist[$];
   logic         bits[$];
   logic [W-1:0] fifo[$];
   logic         e_ready, e_sel, e_clk, e_data, e_dchk;
   logic         e_valid, e_drop, e_lerr, e_rxd_chk;
   int           e_count;
   logic [M-1:0] e_msg;
   logic [H-1:0] e_hdr;

   function automatic bit busy(input int m);
      return active && (m > acc) && (m <= acc + TxBusy);
   endfunction

   // Expected TX pins during cycle m, from the frame timeline after accept
   task automatic tx_expect(input int m);
      int k, b;
      k = m - acc;
      e_ready = !busy(m);
      e_dchk  = 1'b0;
      if (busy(m) && k <= 2 * W * C) begin
         b      = (k - 1) / (2 * C);
         e_sel  = 1'b0;
         e_clk  = ((k - 1) % (2 * C)) >= C;
         e_data = tx_frame[W-1-b];
         e_dchk = 1'b1;
      end else if (busy(m)) begin
         e_sel = 1'b0;
         e_clk = 1'b0;
      end else begin
         e_sel = 1'b1;
         e_clk = 1'b0;
      end
   endtask

   task automatic model_reset();
      active = 0;
      hist.delete();
      repeat (3) hist.push_back(WIdle);
      bits.delete();
      fifo.delete();
      e_ready = 1; e_sel = 1; e_clk = 0; e_data = 0; e_dchk = 1;
      e_valid = 0; e_count = 0; e_drop = 0; e_lerr = 0;
      e_rxd_chk = 1; e_msg = '0; e_hdr = '0;
   endtask

   // Wire seen by the receiver lags the pins by two cycles (hist[0] is last cycle)
   task automatic model_step();
      wire_t        now, s, p;
      logic         pop, push;
      logic [W-1:0] fr;
      now  = manual ? wire_t'({m_sel, m_clk, m_data}) : wire_t'({e_sel, e_clk, e_data});
      s    = hist[1];
      p    = hist[2];
      pop  = (fifo.size() > 0) && rx_ready;
      push = 0;
      fr   = '0;
      e_drop = 0;
      e_lerr = 0;
      if (p.sel && !s.sel) bits.delete();
      else if (!p.clk && s.clk && !s.sel) bits.push_back(s.dat);
      if (!p.sel && s.sel) begin
         if (bits.size() == W) begin
            if (fifo.size() == D && !pop) e_drop = 1;
            else push = 1;
         end else if (bits.size() != 0) begin
            e_lerr = 1;
         end
      end
      if (push) for (int i = 0; i < W; i++) fr = {fr[W-2:0], bits[i]};
      if (pop) void'(fifo.pop_front());
      if (push) fifo.push_back(fr);
      e_valid   = fifo.size() > 0;
      e_count   = fifo.size();
      e_rxd_chk = e_valid;
      if (e_valid) {e_msg, e_hdr} = fifo[0];
      hist.push_front(now);
      void'(hist.pop_back());
      if (!busy(cyc) && tx_valid) begin
         active   = 1;
         acc      = cyc;
         tx_frame = {tx_msg, tx_hdr};
      end
      cyc++;
      tx_expect(cyc);
   endtask

   always @(posedge clk or posedge rst_in) begin
      if (rst_in) model_reset();
      else model_step();
   end

   bit checking = 0;

   always @(negedge clk) begin
      if (checking) begin
         chk("tx_ready", tx_ready, e_ready);
         chk("tx_sel", tx_sel, e_sel);
         chk("tx_clk", tx_clk, e_clk);
         if (e_dchk) chk("tx_data", tx_data, e_data);
         chk("rx_valid", rx_valid, e_valid);
         chk("rx_count", rx_count, e_count);
         chk("rx_drop", rx_drop, e_drop);
         chk("rx_len_err", rx_lerr, e_lerr);
         if (e_rxd_chk) begin
            chk("rx_message", rx_msg, e_msg);
            chk("rx_header", rx_hdr, e_hdr);
         end
      end
   end

   // ---------------- observers ----------------
   logic [W-1:0] got[$];
   logic         mosi[$];
   int           n_drop = 0;
   int           n_lerr = 0;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got.push_back({rx_msg, rx_hdr});
      if (rx_drop) n_drop++;
      if (rx_lerr) n_lerr++;
   end

   always @(posedge tx_clk) mosi.push_back(tx_data);

   // ---------------- stimulus ----------------
   int mcyc = 0;
   int peak = 0;
   int vcyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      mcyc++;
      if (int'(rx_count) > peak) peak = int'(rx_count);
      if (rx_valid) vcyc++;
   endtask

   task automatic tick_n(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!tx_ready && t < 200) begin
         tick();
         t++;
      end
      if (!tx_ready) chk("tx_ready_timeout", tx_ready, 1);
   endtask

   task automatic send(input logic [M-1:0] m, input logic [H-1:0] h, input bit hold,
                       output int a);
      wait_ready();
      tx_msg   = m;
      tx_hdr   = h;
      tx_valid = 1;
      a        = mcyc;
      tick();
      if (!hold) tx_valid = 0;
   endtask

   task automatic pulse_frame(input int n);
      m_sel = 0;
      tick_n(3);
      for (int i = 0; i < n; i++) begin
         m_data = i[0];
         m_clk  = 1;
         tick_n(3);
         m_clk = 0;
         tick_n(3);
      end
      m_sel = 1;
      tick_n(6);
   endtask

   function automatic logic [W-1:0] got_at(input int i);
      return (got.size() > i) ? got[i] : 16'hDEAD;
   endfunction

   initial begin
      int a, a1, a2, a3, t, g, ms, d0, l0;
      logic [W-1:0] v;
      tx_valid = 0; tx_msg = '0; tx_hdr = '0; rx_ready = 0;
      manual = 0; m_sel = 1; m_clk = 0; m_data = 0;
      #1 rst_in = 1;
      #1;
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_tx_sel", tx_sel, 1);
      chk("rst_tx_clk", tx_clk, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_count", rx_count, 0);
      chk("rst_rx_message", rx_msg, 0);
      checking = 1;
      tick_n(3);
      rst_in = 0;
      tick_n(3);

      // Single frame
      rx_ready = 1;
      ms = mosi.size(); g = got.size(); vcyc = 0;
      send(8'hA5, 8'h3C, 0, a);
      t = 1;
      while (!tx_ready && t < 200) begin
         tick();
         t++;
      end
      chk("t1_busy_cycles", t, 67);
      tick_n(8);
      chk("t1_mosi_count", mosi.size() - ms, 16);
      v = '0;
      if (mosi.size() >= ms + 16) for (int i = 0; i < 16; i++) v = {v[W-2:0], mosi[ms+i]};
      chk("t1_mosi_bits", v, 16'hA53C);
      chk("t1_rx_frames", got.size() - g, 1);
      chk("t1_rx_frame", got_at(g), 16'hA53C);
      chk("t1_valid_cycles", vcyc, 1);

      // Back-to-back with valid held
      g = got.size(); peak = 0;
      send(8'h01, 8'h02, 1, a1);
      send(8'hFF, 8'h00, 0, a2);
      chk("t2_accept_gap", a2 - a1, 67);
      tick_n(80);
      chk("t2_rx_frames", got.size() - g, 2);
      chk("t2_frame0", got_at(g), 16'h0102);
      chk("t2_frame1", got_at(g + 1), 16'hFF00);
      chk("t2_peak_count", peak, 1);

      // FIFO full, third frame dropped
      rx_ready = 0; g = got.size(); d0 = n_drop;
      send(8'h11, 8'h12, 1, a);
      send(8'h21, 8'h22, 1, a);
      send(8'h31, 8'h32, 0, a3);
      tick_n(75);
      chk("t3_count_full", rx_count, 2);
      chk("t3_drops", n_drop - d0, 1);
      chk("t3_no_pops", got.size() - g, 0);
      rx_ready = 1;
      tick_n(4);
      rx_ready = 0;
      chk("t3_drained", got.size() - g, 2);
      chk("t3_frame0", got_at(g), 16'h1112);
      chk("t3_frame1", got_at(g + 1), 16'h2122);
      chk("t3_count_empty", rx_count, 0);

      // Hand-driven select windows: short, empty, exact, long
      manual = 1; rx_ready = 1;
      tick_n(2);
      l0 = n_lerr; peak = 0; g = got.size();
      pulse_frame(5);
      chk("t4_len_err_5", n_lerr - l0, 1);
      chk("t4_count_5", peak, 0);
      pulse_frame(0);
      chk("t4_empty_sel", n_lerr - l0, 1);
      pulse_frame(17);
      chk("t4_len_err_17", n_lerr - l0, 2);
      pulse_frame(16);
      chk("t4_len_err_16", n_lerr - l0, 2);
      chk("t4_exact_frame", got_at(g), 16'h5555);
      manual = 0;
      tick_n(2);

      // Full and pop on the push cycle
      rx_ready = 0; g = got.size(); d0 = n_drop;
      send(8'h41, 8'h42, 1, a);
      send(8'h51, 8'h52, 1, a);
      send(8'h61, 8'h62, 0, a3);
      while (mcyc < a3 + 69) tick();
      rx_ready = 1;
      tick();
      rx_ready = 0;
      chk("t5_popped", got.size() - g, 1);
      chk("t5_frame0", got_at(g), 16'h4142);
      tick_n(3);
      chk("t5_count", rx_count, 2);
      chk("t5_no_drop", n_drop - d0, 0);
      rx_ready = 1;
      tick_n(4);
      chk("t5_drained", got.size() - g, 3);
      chk("t5_frame1", got_at(g + 1), 16'h5152);
      chk("t5_frame2", got_at(g + 2), 16'h6162);

      // Reset mid-frame, then a clean frame
      g = got.size(); l0 = n_lerr;
      send(8'h5A, 8'hC3, 0, a);
      while (mcyc < a + 30) tick();
      rst_in = 1;
      #1;
      chk("t6_sel_reset", tx_sel, 1);
      chk("t6_ready_reset", tx_ready, 1);
      chk("t6_clk_reset", tx_clk, 0);
      tick_n(2);
      rst_in = 0;
      tick_n(3);
      send(8'h96, 8'h69, 0, a);
      tick_n(75);
      chk("t6_rx_frames", got.size() - g, 1);
      chk("t6_frame", got_at(g), 16'h9669);
      chk("t6_no_len_err", n_lerr - l0, 0);

      tick_n(4);
      checking = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
